// File: rtl/seven_segment_scanner.sv
// Eight-digit multiplexed hex display scanner: holds the last four UART bytes and
// time-multiplexes their nibbles onto one decoder input with matching anode enables.
module seven_segment_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_Clear,
    output logic [3:0] o_Count,
    output logic [7:0] o_Anode
);

    localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [31:0]      r_buffer;
    logic [2:0]       r_byte_cnt;
    logic [CNT_W-1:0] r_refresh_cnt;
    logic [2:0]       r_digit_idx;
    logic [7:0]       r_anode_pipe;

    logic [31:0]      w_buffer_next;
    logic [2:0]       w_byte_cnt_next;
    logic             w_tick;
    logic             w_lit;
    logic [3:0]       w_nibble;
    logic [7:0]       w_anode_sel;

    assign w_tick = (r_refresh_cnt == CNT_MAX);

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_buffer_next   = r_buffer;
        w_byte_cnt_next = r_byte_cnt;
        if (i_Clear) begin
            w_buffer_next   = 32'h0;
            w_byte_cnt_next = 3'd0;
        end else if (i_RX_DV) begin
            w_buffer_next = {r_buffer[23:0], i_RX_Byte};
            if (r_byte_cnt != 3'd4) begin
                w_byte_cnt_next = r_byte_cnt + 3'd1;
            end
        end
    end

    // Display looks at the post-update buffer so a new byte shows up one edge after it lands.
    assign w_nibble    = w_buffer_next[{r_digit_idx, 2'b00} +: 4];
    assign w_lit       = ({1'b0, r_digit_idx} < {w_byte_cnt_next, 1'b0});
    assign w_anode_sel = w_lit ? ~(8'd1 << r_digit_idx) : 8'hFF;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_buffer      <= 32'h0;
            r_byte_cnt    <= 3'd0;
            r_refresh_cnt <= '0;
            r_digit_idx   <= 3'd0;
            r_anode_pipe  <= 8'hFF;
            o_Count       <= 4'h0;
            o_Anode       <= 8'hFF;
        end else begin
            r_buffer   <= w_buffer_next;
            r_byte_cnt <= w_byte_cnt_next;
            if (w_tick) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= r_digit_idx + 3'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            end
            // Anode trails the nibble by one edge to line up with the registered decoder.
            o_Count      <= w_nibble;
            r_anode_pipe <= w_anode_sel;
            o_Anode      <= r_anode_pipe;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner at REFRESH_DIV=4, with a cycle-level
// expectation model checked every clock plus hand-computed frame checks.
module tb_seven_segment_scanner;

    localparam int DIV = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       clear   = 1'b0;
    logic [3:0] o_count;
    logic [7:0] o_anode;

    always #5 clk = ~clk;

    seven_segment_scanner #(.REFRESH_DIV(DIV)) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_RX_DV   (rx_dv),
        .i_RX_Byte (rx_byte),
        .i_Clear   (clear),
        .o_Count   (o_count),
        .o_Anode   (o_anode)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;

    logic [31:0] m_buf   = 32'h0;
    logic [2:0]  m_cnt   = 3'd0;
    logic [3:0]  m_count = 4'h0;
    logic [7:0]  m_anode = 8'hFF;
    logic [7:0]  m_pipe  = 8'hFF;

    logic [3:0]  last_count = 4'h0;
    logic        collecting = 1'b0;
    int          hits[8];
    logic [3:0]  seen[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: update expectations from the inputs seen at the edge, then compare.
    task automatic step();
        int idx;
        @(posedge clk);
        if (!rst_n) begin
            k       = 0;
            m_buf   = 32'h0;
            m_cnt   = 3'd0;
            m_count = 4'h0;
            m_anode = 8'hFF;
            m_pipe  = 8'hFF;
        end else begin
            k++;
            if (clear) begin
                m_buf = 32'h0;
                m_cnt = 3'd0;
            end else if (rx_dv) begin
                m_buf = {m_buf[23:0], rx_byte};
                if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
            end
            idx     = ((k - 1) / DIV) % 8;
            m_anode = m_pipe;
            m_count = m_buf[idx*4 +: 4];
            m_pipe  = (idx < 2 * int'(m_cnt)) ? ~(8'd1 << idx) : 8'hFF;
        end
        #1;
        check("count", 32'(o_count), 32'(m_count));
        check("anode", 32'(o_anode), 32'(m_anode));
        check("anode_onehot", 32'((o_anode == 8'hFF) || $onehot(~o_anode)), 32'd1);
        if (collecting && o_anode != 8'hFF) begin
            for (int d = 0; d < 8; d++) begin
                if (o_anode == ~(8'd1 << d)) begin
                    hits[d]++;
                    seen[d] = last_count;
                end
            end
        end
        last_count = o_count;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        step();
        rx_dv   = 1'b0;
    endtask

    task automatic collect(input int n);
        for (int d = 0; d < 8; d++) begin
            hits[d] = 0;
            seen[d] = 4'h0;
        end
        collecting = 1'b1;
        repeat (n) step();
        collecting = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] lit_mask();
        logic [7:0] m;
        for (int d = 0; d < 8; d++) m[d] = (hits[d] != 0);
        return m;
    endfunction

    function automatic logic [7:0] full_slot_mask();
        logic [7:0] m;
        for (int d = 0; d < 8; d++) m[d] = (hits[d] == DIV);
        return m;
    endfunction

    initial begin
        // Reset state, then an idle display.
        rst_n = 1'b0;
        step();
        step();
        check("reset_anode", 32'(o_anode), 32'h0000_00FF);
        check("reset_count", 32'(o_count), 32'h0);
        rst_n = 1'b1;
        repeat (64) step();
        check("idle_anode", 32'(o_anode), 32'h0000_00FF);
        check("idle_count", 32'(o_count), 32'h0);

        // Single byte 0xA5: digits 0 and 1 only.
        send(8'hA5);
        repeat (2) step();
        collect(32);
        check("a5_mask", 32'(lit_mask()), 32'h03);
        check("a5_slots", 32'(full_slot_mask()), 32'h03);
        check("a5_digit0", 32'(seen[0]), 32'h5);
        check("a5_digit1", 32'(seen[1]), 32'hA);

        // Five bytes: oldest discarded, all eight digits lit once per frame.
        do_reset();
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        send(8'h9A);
        repeat (2) step();
        collect(32);
        check("five_mask", 32'(lit_mask()), 32'hFF);
        check("five_slots", 32'(full_slot_mask()), 32'hFF);
        check("five_buffer", {seen[7], seen[6], seen[5], seen[4],
                              seen[3], seen[2], seen[1], seen[0]}, 32'h3456_789A);

        // Clear beats a simultaneous byte; the next byte alone then shows.
        send(8'hFF);
        rx_byte = 8'h11;
        rx_dv   = 1'b1;
        clear   = 1'b1;
        step();
        rx_dv   = 1'b0;
        clear   = 1'b0;
        repeat (2) step();
        collect(32);
        check("clear_mask", 32'(lit_mask()), 32'h00);
        send(8'h11);
        repeat (2) step();
        collect(32);
        check("after_clear_mask", 32'(lit_mask()), 32'h03);
        check("after_clear_d0", 32'(seen[0]), 32'h1);
        check("after_clear_d1", 32'(seen[1]), 32'h1);

        // Mid-slot reset at digit index 5 with a byte strobed during reset.
        do_reset();
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        while (k < 21) step();
        rst_n   = 1'b0;
        rx_byte = 8'h77;
        rx_dv   = 1'b1;
        step();
        check("midreset_anode", 32'(o_anode), 32'h0000_00FF);
        check("midreset_count", 32'(o_count), 32'h0);
        rst_n   = 1'b1;
        rx_byte = 8'h3C;
        step();
        rx_dv   = 1'b0;
        repeat (3) step();
        check("pre_tick_count", 32'(o_count), 32'hC);
        step();
        check("first_tick_count", 32'(o_count), 32'h3);
        repeat (4) step();
        check("reset_byte_dropped", 32'(o_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
